// File: rtl/audio_record_buffer_pkg.sv
// Shared definitions for the audio record/playback buffer.
//  - recorder state encoding (REC_IDLE / REC_RECORD / REC_PLAY)
//  - default RAM geometry (address and sample widths)
package audio_record_buffer_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    REC_IDLE   = 2'd0,
    REC_RECORD = 2'd1,
    REC_PLAY   = 2'd2
  } rec_state_e;

endpackage

// File: rtl/audio_record_buffer_ram.sv
// audio_sample_ram: simple dual-port sample store, one write port and one
// synchronous read port (1-cycle latency). The array has no reset so it maps
// onto block RAM; contents survive a recorder reset.
//  clk    in   write and read clock
//  we     in   write enable
//  waddr  in   write address
//  wdata  in   write data
//  raddr  in   read address (registered internally by the read)
//  rdata  out  mem[raddr] from the previous cycle
module audio_sample_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_record_buffer.sv
// audio_record_buffer: records the codec's decoded sample stream into RAM and
// replays it into the codec's input on sample_req.
//  clk, reset_n  audio_clk domain, async active-low reset
//  rec_start     pulse: begin a new take at address 0
//  play_start    pulse: replay current take from address 0 (ignored if empty)
//  stop          pulse: end record or playback
//  sample_end    strobe: sample_in valid (written while recording)
//  sample_req    strobe: codec consumes sample_out (advances while playing)
//  sample_in     codec sample to record
//  sample_out    playback sample, 0 outside PLAY
//  recording     state is RECORD
//  playing       state is PLAY
//  rec_len       samples in current take, 0..DEPTH
//  play_pos      address of the sample on sample_out
//  done          pulse: take filled RAM, or playback hit end of take (LOOP=0)
module audio_record_buffer
  import audio_record_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOOP   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              sample_end,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W:0]   rec_len,
  output logic [ADDR_W-1:0] play_pos,
  output logic              done
);

  localparam logic [ADDR_W-1:0] A_ONE  = 1;
  localparam logic [ADDR_W-1:0] A_LAST = '1;
  localparam logic [ADDR_W:0]   L_ONE  = 1;

  rec_state_e        state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W:0]   rd_nxt;
  // vld_pipe[0]: rd_ptr just changed; vld_pipe[1]: RAM output now holds mem[rd_ptr]
  logic [1:0]        vld_pipe;
  logic              rec_go, play_go, wr_en, full, adv, wrap, fin;

  assign rd_nxt    = {1'b0, rd_ptr} + L_ONE;
  assign recording = (state == REC_RECORD);
  assign playing   = (state == REC_PLAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= REC_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rec_go   = 1'b0;
    play_go  = 1'b0;
    wr_en    = 1'b0;
    full     = 1'b0;
    adv      = 1'b0;
    wrap     = 1'b0;
    fin      = 1'b0;
    case (state)
      REC_IDLE: begin
        if (rec_start) begin
          rec_go   = 1'b1;
          state_nx = REC_RECORD;
        end else if (play_start && rec_len != '0) begin
          play_go  = 1'b1;
          state_nx = REC_PLAY;
        end
      end
      REC_RECORD: begin
        // a sample arriving with stop is still written before leaving
        if (sample_end) begin
          wr_en = 1'b1;
          if (wr_ptr == A_LAST) begin
            full     = 1'b1;
            state_nx = REC_IDLE;
          end
        end
        if (stop) state_nx = REC_IDLE;
      end
      REC_PLAY: begin
        // stop beats a coincident sample_req: no advance
        if (stop) begin
          state_nx = REC_IDLE;
        end else if (sample_req) begin
          if (rd_nxt == rec_len) begin
            if (LOOP != 0) begin
              wrap = 1'b1;
            end else begin
              fin      = 1'b1;
              state_nx = REC_IDLE;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nx = REC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rec_len    <= '0;
      sample_out <= '0;
      play_pos   <= '0;
      done       <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      done     <= full | fin;
      vld_pipe <= {vld_pipe[0], 1'b0};
      if (rec_go) begin
        wr_ptr  <= '0;
        rec_len <= '0;
      end
      if (wr_en) begin
        // last address wraps wr_ptr to 0 while rec_len reaches DEPTH
        wr_ptr  <= wr_ptr + A_ONE;
        rec_len <= {1'b0, wr_ptr} + L_ONE;
      end
      if (play_go || wrap) begin
        rd_ptr   <= '0;
        vld_pipe <= 2'b01;
      end
      if (adv) begin
        rd_ptr   <= rd_ptr + A_ONE;
        vld_pipe <= 2'b01;
      end
      // silence outside PLAY; otherwise load the prefetched sample two
      // cycles after rd_ptr moves (one for address, one for RAM latency)
      if (state_nx != REC_PLAY) begin
        sample_out <= '0;
        play_pos   <= '0;
        vld_pipe   <= '0;
      end else if (vld_pipe[1]) begin
        sample_out <= ram_q;
        play_pos   <= rd_ptr;
      end
    end
  end

  audio_sample_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (sample_in),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

endmodule
